// File: rtl/cpu_data_pkg.sv
`default_nettype none
// ============================================================================
// cpu_data_pkg : opcodes, B-source encodings and FSM states for cpu_data_mc
// Revision     : 1.0
// ============================================================================
package cpu_data_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_ADC = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_SBB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;

    localparam logic [1:0] BSEL_IMM = 2'b00;
    localparam logic [1:0] BSEL_REG = 2'b01;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_data_mc_seq_mul.sv
`default_nettype none
// ============================================================================
// seq_mul  : unsigned shift-add multiplier, one partial product per cycle
// Revision : 1.0
// ============================================================================
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_product,
    output logic                 o_done
);

    localparam int             CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] w_addend;

    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    // Product including the step taken on this edge, so the caller can load it at once
    assign o_product = r_prod + w_addend;
    assign o_last    = r_busy && (r_cnt == C_LAST);
    assign o_done    = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= o_last;
            if (i_start) begin
                r_mcand  <= {{WIDTH{1'b0}}, i_a};
                r_mplier <= i_b;
                r_prod   <= '0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                r_prod   <= o_product;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (o_last) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_data_mc.sv
`default_nettype none
// ============================================================================
// cpu_data_mc : accumulator data path with reg file, data memory, ALU, flags
//               and a multi-cycle multiplier behind a valid/ready handshake
// Revision    : 1.0
// ============================================================================
module cpu_data_mc
    import cpu_data_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NREG   = 8,
    parameter int RSEL_W = 4,
    parameter int DM_AW  = 8
) (
    input  logic              clk,
    input  logic              pc_rst_n,
    input  logic              i_op_valid,
    output logic              o_op_ready,
    input  logic [3:0]        i_alu_op,
    input  logic [1:0]        i_in_b_sel,
    input  logic [WIDTH-1:0]  i_imm,
    input  logic [RSEL_W-1:0] i_reg_f_sel,
    input  logic              i_en_reg_f,
    input  logic [DM_AW-1:0]  i_d_mem_addr,
    input  logic              i_d_mem_addr_mode,
    input  logic              i_en_d_mem,
    output logic [WIDTH-1:0]  o_acc_out,
    output logic [WIDTH-1:0]  o_acc_hi_out,
    output logic              o_flag_z_out,
    output logic              o_flag_c_out,
    output logic              o_flag_n_out,
    output logic              o_mul_done
);

    state_t               r_state, w_state_next;
    logic [WIDTH-1:0]     r_acc, r_acc_hi;
    logic                 r_flag_z, r_flag_c, r_flag_n;
    logic [WIDTH-1:0]     r_regf [NREG];
    logic [WIDTH-1:0]     r_dmem [1 << DM_AW];

    logic                 w_accept, w_mul_start, w_mul_last;
    logic [2*WIDTH-1:0]   w_mul_product;
    logic [WIDTH-1:0]     w_reg_rd, w_b, w_alu_acc;
    logic [DM_AW-1:0]     w_addr;
    logic                 w_alu_c, w_upd;

    assign o_op_ready  = (r_state == ST_IDLE);
    assign w_accept    = i_op_valid && o_op_ready;
    assign w_mul_start = w_accept && (i_alu_op == OP_MUL);

    // Out-of-range selects match no entry and so read as zero
    always_comb begin
        w_reg_rd = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i_reg_f_sel == RSEL_W'(i)) w_reg_rd = r_regf[i];
        end
    end

    assign w_addr = i_d_mem_addr_mode ? w_reg_rd[DM_AW-1:0] : i_d_mem_addr;
    assign w_b    = (i_in_b_sel == BSEL_IMM) ? i_imm :
                    (i_in_b_sel == BSEL_REG) ? w_reg_rd : r_dmem[w_addr];

    always_comb begin
        w_alu_acc = r_acc;
        w_alu_c   = r_flag_c;
        w_upd     = 1'b1;
        case (i_alu_op)
            OP_LD:  w_alu_acc = w_b;
            OP_ADD: {w_alu_c, w_alu_acc} = {1'b0, r_acc} + {1'b0, w_b};
            OP_ADC: {w_alu_c, w_alu_acc} = {1'b0, r_acc} + {1'b0, w_b} + {{WIDTH{1'b0}}, r_flag_c};
            OP_SUB: {w_alu_c, w_alu_acc} = {1'b0, r_acc} - {1'b0, w_b};
            OP_SBB: {w_alu_c, w_alu_acc} = {1'b0, r_acc} - {1'b0, w_b} - {{WIDTH{1'b0}}, r_flag_c};
            OP_AND: w_alu_acc = r_acc & w_b;
            OP_OR:  w_alu_acc = r_acc | w_b;
            OP_XOR: w_alu_acc = r_acc ^ w_b;
            OP_NOT: w_alu_acc = ~r_acc;
            OP_SHL: {w_alu_c, w_alu_acc} = {r_acc, 1'b0};
            OP_SHR: {w_alu_acc, w_alu_c} = {1'b0, r_acc};
            default: w_upd = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_last)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) r_state <= ST_IDLE;
        else           r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            r_acc    <= '0;
            r_acc_hi <= '0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (r_state == ST_MUL) begin
            if (w_mul_last) begin
                r_acc    <= w_mul_product[WIDTH-1:0];
                r_acc_hi <= w_mul_product[2*WIDTH-1:WIDTH];
                r_flag_z <= (w_mul_product == '0);
                r_flag_c <= |w_mul_product[2*WIDTH-1:WIDTH];
                r_flag_n <= w_mul_product[WIDTH-1];
            end
        end else if (w_accept && w_upd) begin
            r_acc    <= w_alu_acc;
            r_flag_c <= w_alu_c;
            r_flag_z <= (w_alu_acc == '0);
            r_flag_n <= w_alu_acc[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            for (int i = 0; i < NREG; i++) r_regf[i] <= '0;
        end else if (w_accept && i_en_reg_f) begin
            for (int i = 0; i < NREG; i++) begin
                if (i_reg_f_sel == RSEL_W'(i)) r_regf[i] <= r_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && i_en_d_mem) r_dmem[w_addr] <= r_acc;
    end

    seq_mul #(.WIDTH(WIDTH)) u_seq_mul (
        .clk       (clk),
        .rst_n     (pc_rst_n),
        .i_start   (w_mul_start),
        .i_a       (r_acc),
        .i_b       (w_b),
        .o_last    (w_mul_last),
        .o_product (w_mul_product),
        .o_done    (o_mul_done)
    );

    assign o_acc_out    = r_acc;
    assign o_acc_hi_out = r_acc_hi;
    assign o_flag_z_out = r_flag_z;
    assign o_flag_c_out = r_flag_c;
    assign o_flag_n_out = r_flag_n;

endmodule
`default_nettype wire

// File: tb/tb_cpu_data_mc.sv
`default_nettype none
// ============================================================================
// tb_cpu_data_mc : scoreboard bench for cpu_data_mc with a behavioural model
// Revision       : 1.0
// ============================================================================
module tb_cpu_data_mc;
    import cpu_data_pkg::*;

    logic       clk = 1'b0;
    logic       pc_rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] alu_op = 4'h0;
    logic [1:0] in_b_sel = 2'b00;
    logic [7:0] imm = 8'h00;
    logic [3:0] reg_f_sel = 4'h0;
    logic       en_reg_f = 1'b0;
    logic [7:0] d_mem_addr = 8'h00;
    logic       d_mem_addr_mode = 1'b0;
    logic       en_d_mem = 1'b0;
    logic [7:0] acc_out, acc_hi_out;
    logic       flag_z, flag_c, flag_n, mul_done;

    always #5 clk = ~clk;

    cpu_data_mc #(.WIDTH(8), .NREG(8), .RSEL_W(4), .DM_AW(8)) dut (
        .clk               (clk),
        .pc_rst_n          (pc_rst_n),
        .i_op_valid        (op_valid),
        .o_op_ready        (op_ready),
        .i_alu_op          (alu_op),
        .i_in_b_sel        (in_b_sel),
        .i_imm             (imm),
        .i_reg_f_sel       (reg_f_sel),
        .i_en_reg_f        (en_reg_f),
        .i_d_mem_addr      (d_mem_addr),
        .i_d_mem_addr_mode (d_mem_addr_mode),
        .i_en_d_mem        (en_d_mem),
        .o_acc_out         (acc_out),
        .o_acc_hi_out      (acc_hi_out),
        .o_flag_z_out      (flag_z),
        .o_flag_c_out      (flag_c),
        .o_flag_n_out      (flag_n),
        .o_mul_done        (mul_done)
    );

    typedef struct packed {
        logic [7:0] acc;
        logic [7:0] hi;
        logic       z, c, n;
    } exp_t;

    exp_t       sb[$];
    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] m_acc, m_hi;
    logic       m_z, m_c, m_n;
    logic [7:0] m_regs [16];
    logic [7:0] m_mem  [256];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_acc"}, 32'(acc_out),    32'(e.acc));
            check_val({tag, "_hi"},  32'(acc_hi_out), 32'(e.hi));
            check_val({tag, "_zcn"}, 32'({flag_z, flag_c, flag_n}), 32'({e.z, e.c, e.n}));
        end
    endtask

    task automatic model_reset();
        m_acc = 8'h00; m_hi = 8'h00; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    endtask

    task automatic model_op(input logic [3:0] op, input logic [1:0] bsel, input logic [7:0] iv,
                            input logic [3:0] sel, input logic enr, input logic [7:0] addr,
                            input logic mode, input logic enm);
        logic [7:0] rv, b, ea;
        int         t;
        logic       upd;
        rv = (sel < 4'd8) ? m_regs[sel] : 8'h00;
        ea = mode ? rv : addr;
        b  = (bsel == 2'b00) ? iv : (bsel == 2'b01) ? rv : m_mem[ea];
        if (enr && sel < 4'd8) m_regs[sel] = m_acc;
        if (enm) m_mem[ea] = m_acc;
        upd = 1'b1;
        t   = int'(m_acc);
        case (op)
            OP_LD:  t = int'(b);
            OP_ADD: begin t = int'(m_acc) + int'(b);                m_c = (t > 255); end
            OP_ADC: begin t = int'(m_acc) + int'(b) + int'(m_c);    m_c = (t > 255); end
            OP_SUB: begin t = int'(m_acc) - int'(b);                m_c = (t < 0);   end
            OP_SBB: begin t = int'(m_acc) - int'(b) - int'(m_c);    m_c = (t < 0);   end
            OP_AND: t = int'(m_acc & b);
            OP_OR:  t = int'(m_acc | b);
            OP_XOR: t = int'(m_acc ^ b);
            OP_NOT: t = int'(~m_acc);
            OP_SHL: begin m_c = m_acc[7]; t = int'(m_acc) * 2; end
            OP_SHR: begin m_c = m_acc[0]; t = int'(m_acc) / 2; end
            OP_MUL: begin
                t     = int'(m_acc) * int'(b);
                m_hi  = 8'(t / 256);
                m_acc = 8'(t % 256);
                m_z   = (t == 0);
                m_c   = (m_hi != 8'h00);
                m_n   = m_acc[7];
                upd   = 1'b0;
            end
            default: upd = 1'b0;
        endcase
        if (upd) begin
            m_acc = 8'(t & 255);
            m_z   = (m_acc == 8'h00);
            m_n   = m_acc[7];
        end
        sb.push_back('{acc: m_acc, hi: m_hi, z: m_z, c: m_c, n: m_n});
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] bsel, input logic [7:0] iv,
                         input logic [3:0] sel, input logic enr, input logic [7:0] addr,
                         input logic mode, input logic enm);
        @(negedge clk);
        alu_op = op; in_b_sel = bsel; imm = iv; reg_f_sel = sel; en_reg_f = enr;
        d_mem_addr = addr; d_mem_addr_mode = mode; en_d_mem = enm; op_valid = 1'b1;
        model_op(op, bsel, iv, sel, enr, addr, mode, enm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [1:0] bsel,
                         input logic [7:0] iv, input logic [3:0] sel, input logic enr,
                         input logic [7:0] addr, input logic mode, input logic enm);
        drive(op, bsel, iv, sel, enr, addr, mode, enm);
        op_valid = 1'b0; en_reg_f = 1'b0; en_d_mem = 1'b0;
        check_state(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_acc"},   32'(acc_out),    32'h0);
        check_val({tag, "_hi"},    32'(acc_hi_out), 32'h0);
        check_val({tag, "_zcn"},   32'({flag_z, flag_c, flag_n}), 32'h0);
        check_val({tag, "_ready"}, 32'(op_ready),   32'h1);
        check_val({tag, "_done"},  32'(mul_done),   32'h0);
    endtask

    int low_cnt;
    int done_cnt;

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        pc_rst_n = 1'b1;

        do_op("ld0",    OP_LD,  2'b00, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("ld0_z", 32'(flag_z), 32'h1);
        do_op("ldF0",   OP_LD,  2'b00, 8'hF0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("add20",  OP_ADD, 2'b00, 8'h20, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("add20_acc_const", 32'(acc_out), 32'h10);
        do_op("sbb10",  OP_SBB, 2'b00, 8'h10, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("sbb10_acc_const", 32'(acc_out), 32'hFF);
        do_op("adc01",  OP_ADC, 2'b00, 8'h01, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("xor",    OP_XOR, 2'b00, 8'hA5, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("shl",    OP_SHL, 2'b00, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("shr",    OP_SHR, 2'b00, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("not",    OP_NOT, 2'b00, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("undef",  4'hF,   2'b00, 8'h12, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        do_op("ld5A",   OP_LD,  2'b00, 8'h5A, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("ld00w3", OP_LD,  2'b00, 8'h00, 4'd3, 1'b1, 8'h00, 1'b0, 1'b0);
        do_op("ldr3",   OP_LD,  2'b01, 8'h00, 4'd3, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("ldr3_acc_const", 32'(acc_out), 32'h5A);
        do_op("nopw12", OP_NOP, 2'b00, 8'h00, 4'd12, 1'b1, 8'h00, 1'b0, 1'b0);
        do_op("ldr12",  OP_LD,  2'b01, 8'h00, 4'd12, 1'b0, 8'h00, 1'b0, 1'b0);

        do_op("ld40",   OP_LD,  2'b00, 8'h40, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("w2",     OP_NOP, 2'b00, 8'h00, 4'd2, 1'b1, 8'h00, 1'b0, 1'b0);
        do_op("ld77",   OP_LD,  2'b00, 8'h77, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("stind",  OP_LD,  2'b00, 8'h00, 4'd2, 1'b0, 8'h00, 1'b1, 1'b1);
        do_op("ldmem",  OP_LD,  2'b10, 8'h00, 4'd0, 1'b0, 8'h40, 1'b0, 1'b0);
        check_val("ldmem_acc_const", 32'(acc_out), 32'h77);

        do_op("ldC8",   OP_LD,  2'b00, 8'hC8, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(OP_MUL, 2'b00, 8'h0A, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        // Keep a conflicting op valid throughout the multiply; it must be ignored
        alu_op = OP_LD; imm = 8'h33; reg_f_sel = 4'd5; en_reg_f = 1'b1; en_d_mem = 1'b1;
        low_cnt = 0;
        while (!op_ready && low_cnt < 20) begin
            check_val("mul_hold_acc", 32'(acc_out), 32'hC8);
            low_cnt++;
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0; en_reg_f = 1'b0; en_d_mem = 1'b0;
        check_val("mul_busy_cycles", 32'(low_cnt), 32'd8);
        check_val("mul_done_pulse",  32'(mul_done), 32'h1);
        check_state("mul");
        check_val("mul_acc_const", 32'({acc_hi_out, acc_out}), 32'h07D0);
        @(posedge clk);
        #1;
        check_val("mul_done_clear", 32'(mul_done), 32'h0);
        check_val("mul_ignored_ld", 32'(acc_out),  32'hD0);
        do_op("ldr5",   OP_LD,  2'b01, 8'h00, 4'd5, 1'b0, 8'h00, 1'b0, 1'b0);

        do_op("ldFF",   OP_LD,  2'b00, 8'hFF, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(OP_MUL, 2'b00, 8'hFF, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        op_valid = 1'b0;
        void'(sb.pop_back());
        repeat (3) @(posedge clk);
        #3;
        pc_rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        pc_rst_n = 1'b1;
        done_cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (mul_done) done_cnt++;
        end
        check_val("no_done_after_abort", 32'(done_cnt), 32'd0);
        check_val("ready_after_abort",   32'(op_ready), 32'h1);
        do_op("ldr3_post", OP_LD, 2'b01, 8'h00, 4'd3, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_data_mc.md
Name: cpu_data_mc

Overview:
- Parametrised successor of the single-cycle CPU data path: accumulator, register file, data memory, ALU and flag register, generalised in width, register count and memory depth.
- Adds an op_valid/op_ready handshake and a multi-cycle shift-add multiplier that produces a double-width result.
- Sits between the control unit (opcode, selects, enables) and the program-counter/branch logic (flag outputs).

Parameters:
- WIDTH, 8, data/accumulator width in bits (>=4).
- NREG, 8, register-file entries.
- RSEL_W, 4, reg_f_sel width; must satisfy 2^RSEL_W >= NREG.
- DM_AW, 8, data-memory address width; depth is 2^DM_AW.

Ports:
- clk  in  1  rising-edge clock.
- pc_rst_n  in  1  reset, asynchronous assert, active-low.
- op_valid  in  1  control presents an operation this cycle.
- op_ready  out  1  data path can accept an operation.
- alu_op  in  4  opcode, from the shared package.
- in_b_sel  in  2  ALU B source: 00 imm, 01 reg_f, 1x data memory.
- imm  in  WIDTH  immediate operand.
- reg_f_sel  in  RSEL_W  register-file index (read and write).
- en_reg_f  in  1  write accumulator into reg[reg_f_sel].
- d_mem_addr  in  DM_AW  direct memory address.
- d_mem_addr_mode  in  1  0: address from d_mem_addr; 1: address from reg_f read value (low DM_AW bits).
- en_d_mem  in  1  write accumulator into data memory.
- acc_out  out  WIDTH  accumulator.
- acc_hi_out  out  WIDTH  high half of the last MUL result.
- flag_z_out, flag_c_out, flag_n_out  out  1 each  zero, carry/borrow, negative (MSB) flags.
- mul_done  out  1  one-cycle pulse when MUL completes.

Behaviour:
- Reset: acc, acc_hi, all flags, mul counter and reg file cleared to 0; state IDLE; op_ready=1; mul_done=0. Data memory is not reset.
- Accept: an operation is accepted on a rising edge where op_valid && op_ready. Nothing changes state without acceptance, including en_reg_f and en_d_mem.
- Reads: reg_f read and data-memory read are combinational. A reg_f_sel >= NREG reads 0, and writes to it are dropped.
- Writes vs ALU: reg/memory writes in an accepted cycle store the pre-edge acc. The same edge may update acc (store-then-compute).
- Single-cycle ops, with B = the selected source; result lands in acc at the accept edge:
  - NOP: acc and flags unchanged.
  - LD: acc=B.
  - ADD / ADC (+C): C=carry out.
  - SUB / SBB (-C): C=borrow.
  - AND, OR, XOR: C unchanged.
  - NOT: acc=~acc.
  - SHL / SHR by 1: C=shifted-out bit, 0 shifted in.
  - Z and N are always recomputed from the new acc, except on NOP.
- MUL (unsigned acc x B):
  - Accept edge: latch multiplicand and multiplier, clear product, state IDLE->MUL, op_ready=0.
  - One shift-add step per cycle for WIDTH cycles. On the WIDTH-th edge after accept: acc = product low half, acc_hi = product high half, Z = (full product==0), C = (high half!=0), N = MSB of the low half; state->IDLE.
  - mul_done=1 and op_ready=1 in the cycle following that edge.
  - During MUL: op_valid ignored, no reg/memory writes, acc and flags hold.
- Reset mid-MUL: abort immediately; no mul_done; all registers return to reset values.
- acc_hi changes only on MUL completion or reset.
- Undefined opcodes behave as NOP.

Decomposition:
- cpu_data_pkg: opcode constants (NOP, LD, ADD, ADC, SUB, SBB, AND, OR, XOR, NOT, SHL, SHR, MUL), in_b_sel encodings, state encoding (IDLE, MUL).
- One sub-module, seq_mul: start/done shift-add multiplier with parameter WIDTH. The top level holds the reg file, data memory, ALU, acc and flags.

Test Plan:
- Reset then LD imm 0x00: all outputs 0, op_ready=1; after LD, Z=1 and N=0.
- LD 0xF0, ADD imm 0x20: acc=0x10, C=1, Z=0. Then SBB imm 0x10 with C=1: acc=0xFF, C=1, N=1.
- LD 0x5A with en_reg_f, reg 3; next cycle LD 0x00; then LD with in_b_sel=01, reg 3: acc=0x5A. A write to reg 12 with NREG=8 is dropped and reads 0.
- Indirect memory: reg 2=0x40; store acc 0x77 with mode 1 and sel 2; then LD from memory at direct address 0x40: acc=0x77.
- LD 0xC8, MUL imm 0x0A:
  - op_ready low for exactly 8 cycles.
  - Then acc=0xD0, acc_hi=0x07, C=1, and mul_done pulses once.
  - op_valid held high during MUL is ignored.
- Start MUL 0xFF x 0xFF, deassert pc_rst_n at cycle 4: all outputs 0 asynchronously, and no mul_done after reset release.
